antirebote_arbitrado: RTL and testbench

- Debounces N push-buttons using one shared stability counter instead of one counter per button.
- A round-robin arbiter assigns the counter to whichever synchronized button disagrees with its debounced output.
- It sits between the raw board buttons and the user logic (menus, counters, FSMs).
- It supplies per-button stable levels plus one-cycle press and release pulses.

---
 rtl/antirebote_arbitrado.sv | 149 ++++++++++++++
 tb/tb_antirebote_arbitrado.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/antirebote_arbitrado.sv
// Debouncer for N push-buttons that share a single stability counter.
// A round-robin arbiter lends the counter to whichever button disagrees with its debounced level.
module antirebote_arbitrado #(
  parameter int unsigned N      = 4,
  parameter int unsigned LIMITE = 50000,
  parameter int unsigned CW     = 16,
  localparam int unsigned CanalW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      btn_in,
  output logic [N-1:0]      btn_out,
  output logic [N-1:0]      pulso_press,
  output logic [N-1:0]      pulso_release,
  output logic              ocupado,
  output logic [CanalW-1:0] canal
);

  typedef enum logic [0:0] {StLibre, StMidiendo} state_e;

  state_e state_q, state_d;

  logic [N-1:0]      sync_q, btn_s_q;
  logic [N-1:0]      btn_out_q, btn_out_d;
  logic [N-1:0]      press_q, press_d;
  logic [N-1:0]      release_q, release_d;
  logic              ocupado_q, ocupado_d;
  logic [CanalW-1:0] canal_q, canal_d;
  logic [CanalW-1:0] ultimo_q, ultimo_d;
  logic [CW-1:0]     contador_q, contador_d;

  logic [N-1:0]      req;
  logic              grant_valid;
  logic [CanalW-1:0] grant_idx;
  logic              abortar;
  logic              fin;

  assign req     = btn_s_q ^ btn_out_q;
  assign abortar = (btn_s_q[canal_q] == btn_out_q[canal_q]);
  assign fin     = (contador_q == CW'(LIMITE - 1));

  // Round-robin search starting just after the last served channel.
  always_comb begin
    int unsigned       idx;
    logic [CanalW-1:0] idx_c;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_c       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ultimo_q) + 32'd1 + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      idx_c = CanalW'(idx);
      if (!grant_valid && req[idx_c]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StLibre;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StLibre:    if (grant_valid) state_d = StMidiendo;
      StMidiendo: if (abortar || fin) state_d = StLibre;
      default:    state_d = StLibre;
    endcase
  end

  always_comb begin
    btn_out_d  = btn_out_q;
    press_d    = '0;
    release_d  = '0;
    ocupado_d  = ocupado_q;
    canal_d    = canal_q;
    contador_d = contador_q;
    ultimo_d   = ultimo_q;
    case (state_q)
      StLibre: begin
        ocupado_d = 1'b0;
        if (grant_valid) begin
          canal_d    = grant_idx;
          contador_d = '0;
          ocupado_d  = 1'b1;
        end
      end
      StMidiendo: begin
        // Only a return to the accepted level aborts; repeated disagreement keeps counting.
        if (abortar) begin
          ultimo_d  = canal_q;
          ocupado_d = 1'b0;
        end else if (fin) begin
          btn_out_d[canal_q] = btn_s_q[canal_q];
          if (btn_s_q[canal_q]) begin
            press_d[canal_q] = 1'b1;
          end else begin
            release_d[canal_q] = 1'b1;
          end
          ultimo_d  = canal_q;
          ocupado_d = 1'b0;
        end else begin
          contador_d = contador_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      btn_s_q    <= '0;
      btn_out_q  <= '0;
      press_q    <= '0;
      release_q  <= '0;
      ocupado_q  <= 1'b0;
      canal_q    <= '0;
      contador_q <= '0;
      ultimo_q   <= CanalW'(N - 1);
    end else begin
      sync_q     <= btn_in;
      btn_s_q    <= sync_q;
      btn_out_q  <= btn_out_d;
      press_q    <= press_d;
      release_q  <= release_d;
      ocupado_q  <= ocupado_d;
      canal_q    <= canal_d;
      contador_q <= contador_d;
      ultimo_q   <= ultimo_d;
    end
  end

  assign btn_out       = btn_out_q;
  assign pulso_press   = press_q;
  assign pulso_release = release_q;
  assign ocupado       = ocupado_q;
  assign canal         = canal_q;

endmodule

// File: tb/tb_antirebote_arbitrado.sv
// Directed bench for antirebote_arbitrado with N=4, LIMITE=4: per-edge vector table plus
// hand-written reset sequences.
module tb_antirebote_arbitrado;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_out;
  logic [3:0] pulso_press;
  logic [3:0] pulso_release;
  logic       ocupado;
  logic [1:0] canal;

  int n_vec;
  int n_bad;

  antirebote_arbitrado #(
    .N      (4),
    .LIMITE (4),
    .CW     (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .btn_out       (btn_out),
    .pulso_press   (pulso_press),
    .pulso_release (pulso_release),
    .ocupado       (ocupado),
    .canal         (canal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_rst;
    logic [3:0] bin;
    logic [3:0] out;
    logic [3:0] pr;
    logic [3:0] rl;
    logic       oc;
    logic [1:0] ca;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] bin, input logic [3:0] out,
                     input logic [3:0] pr, input logic [3:0] rl, input logic oc,
                     input logic [1:0] ca, input int reps);
    for (int i = 0; i < reps; i++) begin
      vec_t v;
      v.do_rst = r && (i == 0);
      v.bin    = bin;
      v.out    = out;
      v.pr     = pr;
      v.rl     = rl;
      v.oc     = oc;
      v.ca     = ca;
      tbl.push_back(v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] actual();
    return {btn_out, pulso_press, pulso_release, ocupado, canal};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got out/press/rel/ocu/canal=%b required %b", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] hold);
    btn_in = hold;
    rst    = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] e_out, e_pr;
    logic       e_oc;
    logic [1:0] e_ca;
    n_vec  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    btn_in = 4'b1111;

    // Clean press ch2, then a 2-cycle bounce on ch1, then press and release of ch1.
    add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 2);
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 2'd2, 4);
    add(0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 0, 2'd2, 1);
    add(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 2'd2, 1);
    add(0, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 0, 2'd2, 2);
    add(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1, 2'd1, 2);
    add(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 2'd1, 3);
    add(0, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 0, 2'd1, 2);
    add(0, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 1, 2'd1, 4);
    add(0, 4'b0110, 4'b0110, 4'b0010, 4'b0000, 0, 2'd1, 1);
    add(0, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 0, 2'd1, 1);
    add(0, 4'b0100, 4'b0110, 4'b0000, 4'b0000, 0, 2'd1, 2);
    add(0, 4'b0100, 4'b0110, 4'b0000, 4'b0000, 1, 2'd1, 4);
    add(0, 4'b0100, 4'b0100, 4'b0000, 4'b0010, 0, 2'd1, 1);
    add(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 2'd1, 1);
    // Contention ch0/ch3 on press, then on release with ch3 last served.
    add(1, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 2);
    add(0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1, 2'd0, 4);
    add(0, 4'b1001, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 1);
    add(0, 4'b1001, 4'b0001, 4'b0000, 4'b0000, 1, 2'd3, 4);
    add(0, 4'b1001, 4'b1001, 4'b1000, 4'b0000, 0, 2'd3, 1);
    add(0, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 0, 2'd3, 1);
    add(0, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 0, 2'd3, 2);
    add(0, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 1, 2'd0, 4);
    add(0, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 0, 2'd0, 1);
    add(0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1, 2'd3, 4);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 2'd3, 1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd3, 1);

    // Buttons held through reset, then sequential re-debounce of all four.
    step();
    step();
    check("reset_held", actual(), 15'd0);
    rst = 1'b1;
    for (int e = 1; e <= 23; e++) begin
      step();
      e_ca  = (e >= 3) ? 2'((((e - 3) / 5) > 3) ? 3 : (e - 3) / 5) : 2'd0;
      e_oc  = (e >= 3) && (e <= 21) && (((e - 3) % 5) != 4);
      e_pr  = (e >= 7 && e <= 22 && ((e - 7) % 5) == 0) ? 4'(1 << ((e - 7) / 5)) : 4'b0000;
      e_out = '0;
      for (int k = 0; k < 4; k++) begin
        if (7 + 5 * k <= e) e_out[k] = 1'b1;
      end
      check($sformatf("reset_release_e%0d", e), actual(), {e_out, e_pr, 4'b0000, e_oc, e_ca});
    end

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset(4'b0000);
      btn_in = tbl[i].bin;
      step();
      check($sformatf("vec%0d", i), actual(),
            {tbl[i].out, tbl[i].pr, tbl[i].rl, tbl[i].oc, tbl[i].ca});
    end

    // Reset asserted mid-measurement on ch2.
    do_reset(4'b0000);
    btn_in = 4'b0100;
    repeat (4) step();
    check("mid_measure", actual(), {4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2});
    #2 rst = 1'b0;
    #1 check("async_clear", actual(), 15'd0);
    step();
    step();
    rst = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      e_out = (e >= 7) ? 4'b0100 : 4'b0000;
      e_pr  = (e == 7) ? 4'b0100 : 4'b0000;
      e_oc  = (e >= 3) && (e <= 6);
      e_ca  = (e >= 3) ? 2'd2 : 2'd0;
      check($sformatf("after_reset_e%0d", e), actual(), {e_out, e_pr, 4'b0000, e_oc, e_ca});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
